// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, iterative-op decode.
// ALU_MUL_EN adds op 9 (iterative multiply) to the set of multi-cycle ops.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_LD  = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ops that are computed by the iterative datapath rather than in one EXEC cycle.
  function automatic logic op_is_iter(input logic [ALU_OP_W-1:0] op);
`ifdef ALU_MUL_EN
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
`else
    return (op == OP_SHL) || (op == OP_SHR);
`endif
  endfunction

endpackage

// File: rtl/alu_shift_mul.sv
// Iterative datapath: one-bit-per-cycle shifts and (with ALU_MUL_EN) shift-add multiply.
// Loads on start; done is high whenever the iteration counter is zero.
module alu_shift_mul
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0]    b,
`endif
  input  logic [SHAMT_W-1:0]  k,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_shl;
  logic             c, c_nxt;

`ifdef ALU_MUL_EN
  // {hi, sh} is the running product; sh starts as the multiplier and drains LSB-first.
  logic             is_mul;
  logic [WIDTH-1:0] mcand, hi, hi_nxt;
  logic [WIDTH:0]   sum;
`endif

  always_comb begin
    sh_nxt = is_shl ? (sh << 1) : (sh >> 1);
    c_nxt  = is_shl ? sh[WIDTH-1] : sh[0];
`ifdef ALU_MUL_EN
    sum    = {1'b0, hi} + (sh[0] ? {1'b0, mcand} : '0);
    hi_nxt = sum[WIDTH:1];
    if (is_mul) begin
      sh_nxt = {sum[0], sh[WIDTH-1:1]};
      c_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh     <= '0;
      cnt    <= '0;
      is_shl <= 1'b0;
      c      <= 1'b0;
`ifdef ALU_MUL_EN
      is_mul <= 1'b0;
      mcand  <= '0;
      hi     <= '0;
`endif
    end else if (start) begin
      c      <= 1'b0;
      is_shl <= (op == OP_SHL);
`ifdef ALU_MUL_EN
      is_mul <= (op == OP_MUL);
      mcand  <= a;
      hi     <= '0;
      if (op == OP_MUL) begin
        sh  <= b;
        cnt <= CNT_W'(WIDTH);
      end else begin
        sh  <= a;
        cnt <= CNT_W'(k);
      end
`else
      sh     <= a;
      cnt    <= CNT_W'(k);
`endif
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      sh  <= sh_nxt;
      c   <= c_nxt;
`ifdef ALU_MUL_EN
      hi  <= hi_nxt;
`endif
    end
  end

  assign done   = (cnt == '0);
  assign result = sh;
`ifdef ALU_MUL_EN
  assign cout   = is_mul ? (|hi) : c;
`else
  assign cout   = c;
`endif

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, registered C/Z/N/V flags and multi-cycle shifts.
// Define ALU_MUL_EN to enable op 9 (iterative unsigned multiply); otherwise op 9 is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    R,
  input  logic                Ci,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic                Co,
  output logic                Z,
  output logic                N,
  output logic                V,
  output logic                err,
  output logic [1:0]          dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // out/flags are held unchanged while out_valid is high and out_ready is low.

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_DONE = DONE;
  localparam int         MSB    = WIDTH - 1;

  logic [1:0]          state;
  logic                live;
  logic [WIDTH-1:0]    a_q, r_q;
  logic                ci_q;
  logic [ALU_OP_W-1:0] op_q;
  logic                accept;

  logic                iter_done, iter_co;
  logic [WIDTH-1:0]    iter_res;

  logic [WIDTH:0]      sum, diff;
  logic [WIDTH-1:0]    res;
  logic                res_c, res_v, res_e;

  // live keeps in_ready low while reset is held and for the reset cycle itself.
  assign in_ready  = live && (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  alu_shift_mul #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .op     (op),
    .a      (A),
`ifdef ALU_MUL_EN
    .b      (R),
`endif
    .k      (R[SHAMT_W-1:0]),
    .done   (iter_done),
    .result (iter_res),
    .cout   (iter_co)
  );

  assign sum  = {1'b0, a_q} + {1'b0, r_q} + {{WIDTH{1'b0}}, ci_q};
  assign diff = {1'b0, a_q} - {1'b0, r_q} - {{WIDTH{1'b0}}, ci_q};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    case (op_q)
      OP_ADD: begin
        {res_c, res} = sum;
        res_v = (a_q[MSB] == r_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        {res_c, res} = diff;
        res_v = (a_q[MSB] != r_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND: res = a_q & r_q;
      OP_OR:  res = a_q | r_q;
      OP_XOR: res = a_q ^ r_q;
      OP_NOT: res = ~a_q;
      OP_LD:  res = r_q;
      OP_SHL, OP_SHR: begin
        res   = iter_res;
        res_c = iter_co;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res   = iter_res;
        res_c = iter_co;
      end
`endif
      default: res_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      live  <= 1'b0;
      a_q   <= '0;
      r_q   <= '0;
      ci_q  <= 1'b0;
      op_q  <= '0;
      out   <= '0;
      Co    <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
      err   <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          a_q   <= A;
          r_q   <= R;
          ci_q  <= Ci;
          op_q  <= op;
          state <= S_EXEC;
        end
        S_EXEC: if (!op_is_iter(op_q) || iter_done) begin
          out   <= res;
          Co    <= res_c;
          Z     <= (res == '0);
          N     <= res[MSB];
          V     <= res_v;
          err   <= res_e;
          state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
